// File: rtl/sss_corr_search.sv
// SSS correlation search: captures one received block, sweeps every ROM candidate and reports the best match.
// Optional macro SSS_CORR_ABS_METRIC_EN ranks candidates by |correlation| instead of signed correlation.
module sss_corr_search #(
    parameter int pRX_W    = 12,
    parameter int pROM_W   = 4,
    parameter int pSEQ_LEN = 64,
    parameter int pNUM_SEQ = 16,
    parameter int pACC_W   = 22
) (
    input  logic                        iclk,
    input  logic                        irstn,
    input  logic                        istart,
    input  logic                        ival,
    input  logic [pRX_W-1:0]            idat,
    output logic                        orom_val,
    output logic [10:0]                 orom_addr,
    input  logic [pROM_W-1:0]           irom_dat,
    output logic                        obusy,
    output logic                        odone,
    output logic [$clog2(pNUM_SEQ)-1:0] oidx,
    output logic [pACC_W-1:0]           ometric
);
    localparam int LW    = $clog2(pSEQ_LEN);
    localparam int KW    = $clog2(pNUM_SEQ);
    localparam int AW    = LW + KW;
    localparam int PW    = pRX_W + pROM_W;
    localparam int TOTAL = pSEQ_LEN * pNUM_SEQ;

    typedef enum logic [2:0] {IDLE, LOAD, SEARCH, FLUSH, DONE} state_t;

    state_t state, next_state;

    logic signed [pRX_W-1:0]  buffer [pSEQ_LEN];
    logic [LW-1:0]            wr_ptr;
    logic [AW-1:0]            addr;
    logic                     s1_val, s2_val;
    logic [AW-1:0]            s1_addr, s2_addr;
    logic signed [pRX_W-1:0]  s1_sample;
    logic signed [pROM_W-1:0] rom_s;
    logic signed [PW-1:0]     prod;
    logic signed [pACC_W-1:0] acc, acc_base, acc_next;
    logic [pACC_W-1:0]        best, metric;
    logic [KW-1:0]            best_idx, cand_k;
    logic                     take, start_ok;

    assign start_ok  = (state == IDLE) && istart && !odone;
    assign orom_val  = (state == SEARCH);
    assign orom_addr = 11'(addr);
    assign rom_s     = irom_dat;

    always_ff @(posedge iclk or negedge irstn) begin
        if (!irstn) state <= IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start_ok) next_state = LOAD;
            LOAD:    if (ival && wr_ptr == LW'(pSEQ_LEN - 1)) next_state = SEARCH;
            SEARCH:  if (addr == AW'(TOTAL - 1)) next_state = FLUSH;
            FLUSH:   if (s2_val && s2_addr == AW'(TOTAL - 1)) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge iclk) begin
        if (state == LOAD && ival) buffer[wr_ptr] <= idat;
    end

    // Candidate-end decision; acc_next is the full correlation when s2_addr is the last sample of a candidate.
    always_comb begin
        acc_base = (s2_addr[LW-1:0] == '0) ? '0 : acc;
        acc_next = acc_base + pACC_W'(prod);
        cand_k   = s2_addr[AW-1:LW];
`ifdef SSS_CORR_ABS_METRIC_EN
        if (!acc_next[pACC_W-1])
            metric = acc_next;
        else if (acc_next == {1'b1, {(pACC_W-1){1'b0}}})
            metric = {1'b0, {(pACC_W-1){1'b1}}};
        else
            metric = -acc_next;
        take = (cand_k == '0) || (metric > best);
`else
        metric = acc_next;
        take   = (cand_k == '0) || ($signed(metric) > $signed(best));
`endif
    end

    always_ff @(posedge iclk or negedge irstn) begin
        if (!irstn) begin
            wr_ptr    <= '0;
            addr      <= '0;
            s1_val    <= 1'b0;
            s1_addr   <= '0;
            s1_sample <= '0;
            s2_val    <= 1'b0;
            s2_addr   <= '0;
            prod      <= '0;
            acc       <= '0;
            best      <= '0;
            best_idx  <= '0;
            obusy     <= 1'b0;
            odone     <= 1'b0;
            oidx      <= '0;
            ometric   <= '0;
        end else begin
            odone <= 1'b0;
            if (start_ok) begin
                obusy  <= 1'b1;
                wr_ptr <= '0;
                addr   <= '0;
            end
            if (state == LOAD && ival) wr_ptr <= wr_ptr + 1'b1;
            if (state == SEARCH) addr <= addr + 1'b1;
            // ROM data returns one cycle after the address, so the buffer sample is delayed to match.
            s1_val    <= (state == SEARCH);
            s1_addr   <= addr;
            s1_sample <= buffer[addr[LW-1:0]];
            s2_val    <= s1_val;
            s2_addr   <= s1_addr;
            prod      <= PW'(s1_sample) * PW'(rom_s);
            if (s2_val) begin
                acc <= acc_next;
                if (s2_addr[LW-1:0] == LW'(pSEQ_LEN - 1) && take) begin
                    best     <= metric;
                    best_idx <= cand_k;
                end
            end
            if (state == DONE) begin
                odone   <= 1'b1;
                obusy   <= 1'b0;
                oidx    <= best_idx;
                ometric <= best;
            end
        end
    end
endmodule

// File: tb/tb_sss_corr_search.sv
// Directed self-checking bench for sss_corr_search with a behavioural ROM and a reference correlator.
// Expectations follow SSS_CORR_ABS_METRIC_EN when it is defined for the build.
module tb_sss_corr_search;
    localparam int SEQ   = 64;
    localparam int NSEQ  = 16;
    localparam int ACC_W = 22;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        val = 1'b0;
    logic [11:0] dat = '0;
    logic        rom_val;
    logic [10:0] rom_addr;
    logic [3:0]  rom_q = '0;
    logic        busy, done;
    logic [3:0]  idx;
    logic [ACC_W-1:0] metric;

    int          n_checks = 0;
    int          n_fail = 0;
    int          pat [SEQ];
    int          rx [SEQ];
    logic [3:0]  rom [2048];
    int          done_cnt = 0;
    int          val_cycles = 0;
    int          addr_err = 0;
    logic        prev_val = 1'b0;
    logic [10:0] prev_addr = '0;

    sss_corr_search dut (
        .iclk(clk), .irstn(rst_n), .istart(start), .ival(val), .idat(dat),
        .orom_val(rom_val), .orom_addr(rom_addr), .irom_dat(rom_q),
        .obusy(busy), .odone(done), .oidx(idx), .ometric(metric)
    );

    always #5 clk = ~clk;

    // ROM read port with one cycle of latency.
    always @(posedge clk) if (rom_val) rom_q <= rom[rom_addr];

    always @(negedge clk) begin
        if (done) done_cnt++;
        if (rom_val) begin
            if (prev_val ? (rom_addr != prev_addr + 11'd1) : (rom_addr != 11'd0)) addr_err++;
            val_cycles++;
        end
        prev_val  = rom_val;
        prev_addr = rom_addr;
    end

    task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic fill_rom();
        for (int a = 0; a < 2048; a++) begin
            int k, i;
            k = a / SEQ;
            i = a % SEQ;
            rom[a] = 4'(((i * k + k) % 3) - 1);
        end
    endtask

    task automatic set_cand(input int k, input int s);
        for (int i = 0; i < SEQ; i++) rom[k * SEQ + i] = 4'(s * pat[i]);
    endtask

    function automatic void ref_search(output int best_idx, output logic [ACC_W-1:0] best_m);
        longint best, m, acc;
        logic signed [3:0] r;
        best = 0;
        best_idx = 0;
        for (int k = 0; k < NSEQ; k++) begin
            acc = 0;
            for (int i = 0; i < SEQ; i++) begin
                r = rom[k * SEQ + i];
                acc += longint'(rx[i]) * longint'(r);
            end
`ifdef SSS_CORR_ABS_METRIC_EN
            m = (acc < 0) ? -acc : acc;
            if (m > 2097151) m = 2097151;
`else
            m = acc;
`endif
            if (k == 0 || m > best) begin
                best = m;
                best_idx = k;
            end
        end
        best_m = ACC_W'(best);
    endfunction

    task automatic apply_stimulus(input bit gapped);
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        for (int i = 0; i < SEQ; i++) begin
            if (gapped && i == SEQ - 1) check_output("gap_no_early_search", 64'(rom_val), 64'd0);
            val = 1'b1;
            dat = 12'(rx[i]);
            @(posedge clk); #1;
            val = 1'b0;
            if (gapped && i != SEQ - 1) begin
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic wait_done(output int cycles);
        cycles = 0;
        while (done !== 1'b1 && cycles < 2000) begin
            @(posedge clk); #1;
            cycles++;
            start = (cycles == 100);
        end
        start = 1'b0;
    endtask

    task automatic run_and_check(input string tag, input bit gapped, input logic [63:0] exp_idx,
                                 input logic [63:0] exp_metric);
        int cyc, v0, e0;
        v0 = val_cycles;
        e0 = addr_err;
        apply_stimulus(gapped);
        wait_done(cyc);
        check_output({tag, "_latency"}, 64'(cyc), 64'd1027);
        check_output({tag, "_done"}, 64'(done), 64'd1);
        check_output({tag, "_busy_low"}, 64'(busy), 64'd0);
        check_output({tag, "_idx"}, 64'(idx), exp_idx);
        check_output({tag, "_metric"}, 64'(metric), exp_metric);
        check_output({tag, "_rom_cycles"}, 64'(val_cycles - v0), 64'd1024);
        check_output({tag, "_addr_seq"}, 64'(addr_err - e0), 64'd0);
        start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        check_output({tag, "_start_on_done"}, 64'(busy), 64'd0);
        check_output({tag, "_done_pulse"}, 64'(done), 64'd0);
    endtask

    initial begin
        int m_idx, d0;
        logic [ACC_W-1:0] m_val;
        for (int i = 0; i < SEQ; i++) pat[i] = (((i ^ (i >> 2) ^ (i >> 3)) & 1) != 0) ? 1 : -1;

        repeat (3) @(posedge clk);
        #1;
        check_output("rst_busy", 64'(busy), 64'd0);
        check_output("rst_done", 64'(done), 64'd0);
        check_output("rst_rom_val", 64'(rom_val), 64'd0);
        check_output("rst_rom_addr", 64'(rom_addr), 64'd0);
        check_output("rst_idx", 64'(idx), 64'd0);
        check_output("rst_metric", 64'(metric), 64'd0);
        rst_n = 1'b1;

        $display("[TB] exact match on candidate 5");
        fill_rom();
        set_cand(5, 1);
        for (int i = 0; i < SEQ; i++) rx[i] = 100 * pat[i];
        run_and_check("exact", 1'b0, 64'd5, 64'd6400);

        $display("[TB] gapped input");
        run_and_check("gapped", 1'b1, 64'd5, 64'd6400);

        $display("[TB] tie between candidates 3 and 9");
        fill_rom();
        set_cand(3, 1);
        set_cand(9, 1);
        run_and_check("tie", 1'b0, 64'd3, 64'd6400);

        $display("[TB] full-scale samples against candidate 7");
        fill_rom();
        for (int i = 0; i < SEQ; i++) begin
            rom[7 * SEQ + i] = 4'b1000;
            rx[i] = -2048;
        end
        run_and_check("fullscale", 1'b0, 64'd7, 64'd1048576);

        $display("[TB] polarity-inverted candidate 5");
        fill_rom();
        set_cand(5, 1);
        for (int i = 0; i < SEQ; i++) rx[i] = -100 * pat[i];
`ifdef SSS_CORR_ABS_METRIC_EN
        run_and_check("inverted", 1'b0, 64'd5, 64'd6400);
`else
        ref_search(m_idx, m_val);
        check_output("inverted_model_not5", 64'(m_idx == 5), 64'd0);
        run_and_check("inverted", 1'b0, 64'(m_idx), 64'(m_val));
        check_output("inverted_idx_not5", 64'(idx == 4'd5), 64'd0);
`endif

        $display("[TB] reset during search");
        apply_stimulus(1'b0);
        repeat (300) @(posedge clk);
        #1;
        check_output("midrst_in_search", 64'(rom_val), 64'd1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        check_output("midrst_busy", 64'(busy), 64'd0);
        check_output("midrst_rom_val", 64'(rom_val), 64'd0);
        check_output("midrst_idx", 64'(idx), 64'd0);
        check_output("midrst_metric", 64'(metric), 64'd0);
        d0 = done_cnt;
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (1200) @(posedge clk);
        #1;
        check_output("midrst_no_done", 64'(done_cnt - d0), 64'd0);
        check_output("midrst_idle_busy", 64'(busy), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
